code_correlator: RTL and testbench
==================================

# code_correlator

Accumulate-and-dump correlator for one tracking channel. It takes the early, prompt and late C/A chips and the `dump_enable` pulse from the channel code generator, multiplies each chip against the carrier-wiped baseband I/Q samples, and integrates the six products over one C/A code period. On each dump it latches the six sums into a bus-readable result set and raises a valid flag that the processor clears with a read acknowledge.

## Interface
Parameters:
- `IN_W`, 4: width of the signed two's-complement baseband sample inputs.
- `ACC_W`, 16: width of the signed running and latched accumulators; must be greater than `IN_W`.

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `prn_key_enable` input 1: channel restart pulse, the same pulse that restarts the code generator; synchronous clear.
- `sample_enable` input 1: a valid baseband sample is present this cycle.
- `mix_i` input IN_W: signed in-phase baseband sample.
- `mix_q` input IN_W: signed quadrature baseband sample.
- `early` input 1: early C/A chip.
- `prompt` input 1: prompt C/A chip.
- `late` input 1: late C/A chip.
- `dump_enable` input 1: one-cycle pulse marking the end of the code period.
- `acc_ack` input 1: one-cycle pulse, processor has read the result set.
- `i_early`, `q_early`, `i_prompt`, `q_prompt`, `i_late`, `q_late` output ACC_W each: latched signed sums.
- `acc_valid` output 1: a new result set is available.
- `overrun` output 1: a result set was overwritten before it was acknowledged.
- `dump_count` output 8: count of dumps since restart, wraps modulo 256.

## Operation
- **Chip mapping.** Chip 0 maps to +1 and chip 1 maps to −1 (BPSK).
- **Accumulation.** On each cycle with `sample_enable` high, each of the six running accumulators adds its term:
  - `i_early` adds +`mix_i` or −`mix_i` according to the `early` chip; the other five follow the same rule.
  - Inputs are sign-extended to ACC_W before the add or subtract.
- **Negation of the minimum input.** Negating −2^(IN_W−1) gives +2^(IN_W−1); this is exact in ACC_W.
- **Dump.** On `dump_enable`:
  - Each latched output takes the running value plus the contribution of the current cycle's sample, if `sample_enable` is high that cycle.
  - Each running accumulator is cleared to 0. The current sample does not carry into the next period.
  - `dump_count` increments.
  - `acc_valid` is set.
- **Overrun.** If `acc_valid` is already 1 when a dump occurs and `acc_ack` is not high in the same cycle:
  - `overrun` is set.
  - The latched outputs are overwritten with the new sums.
- **Acknowledge.** `acc_ack` clears both `acc_valid` and `overrun`.
- **Dump and acknowledge in the same cycle.** The dump wins: `acc_valid` is 1 afterwards, `overrun` is not set, and the previously set `overrun` is cleared.
- **`acc_ack` with `acc_valid` low.** No effect.
- **Restart.** `prn_key_enable` clears the running accumulators, latched outputs, `acc_valid`, `overrun` and `dump_count`. It has priority over a simultaneous `dump_enable`, `sample_enable` or `acc_ack`.
- **Reset.** Asserting `rstn` low mid-period clears every register immediately. Accumulation restarts from 0 on the first sample after release.

## Timing
- Reset value of every output is 0.
- A sample's contribution reaches the running accumulator one clock after the cycle in which it is presented.
- Latched outputs, `acc_valid`, `overrun` and `dump_count` update on the clock edge that samples `dump_enable`. They are visible in the following cycle, i.e. one cycle of latency.
- `acc_valid` and `overrun` clear on the edge that samples `acc_ack`.
- No combinational path exists from any input to any output.
- `dump_enable` is guaranteed by the code generator to occur at least 2 cycles apart. Back-to-back dumps one cycle apart are still handled per the rules above.

## Configuration
- `CORR_SATURATE_EN` defined:
  - Every running-accumulator add or subtract saturates at +2^(ACC_W−1)−1 and −2^(ACC_W−1).
  - The value carried into the latch at dump saturates the same way.
- `CORR_SATURATE_EN` undefined: accumulators wrap modulo 2^ACC_W (plain two's-complement).

## Test plan
- **Basic accumulate.** After reset, hold `early`=`prompt`=`late`=0, `mix_i`=3, `mix_q`=−2, `sample_enable`=1 for 10 cycles, pulse `dump_enable` on cycle 10.
  - Expect all `i_*` = 30 and all `q_*` = −20.
  - Expect `acc_valid`=1 and `dump_count`=1.
- **Chip sign and half-chip spacing.** `early`=1, `prompt`=0, `late`=1, `mix_i`=5, 4 samples, dump.
  - Expect `i_early`=−20, `i_prompt`=20, `i_late`=−20.
- **Overrun.** Two dumps with no `acc_ack` between them.
  - Expect `overrun`=1, outputs equal to the second period's sums, and `dump_count`=2.
  - Then pulse `acc_ack` and expect `acc_valid`=0 and `overrun`=0.
- **Simultaneous dump and acknowledge.** Pulse `dump_enable` and `acc_ack` in the same cycle with `acc_valid`=1.
  - Expect `acc_valid`=1 and `overrun`=0.
  - Separately, pulse `prn_key_enable` together with `dump_enable` and expect every output = 0.
- **Saturation.** `mix_i`=7, chip 0, 5000 samples, dump.
  - With `CORR_SATURATE_EN`: expect `i_prompt`=32767.
  - Without it: expect (35000 mod 65536) read as signed, i.e. −30536.
- **Async reset mid-period.** Accumulate 100 samples, drop `rstn` between clock edges.
  - Expect all outputs 0 immediately.
  - After release, 3 samples of `mix_i`=1 then a dump give `i_prompt`=3.

Source files
------------

// File: rtl/code_correlator.sv
// Accumulate-and-dump correlator: six E/P/L x I/Q integrators with a latched, acknowledged result set.
// Optional saturating arithmetic is enabled with CORR_SATURATE_EN (default: two's-complement wrap).
module code_correlator #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    prn_key_enable,
  input  logic                    sample_enable,
  input  logic signed [IN_W-1:0]  mix_i,
  input  logic signed [IN_W-1:0]  mix_q,
  input  logic                    early,
  input  logic                    prompt,
  input  logic                    late,
  input  logic                    dump_enable,
  input  logic                    acc_ack,
  output logic signed [ACC_W-1:0] i_early,
  output logic signed [ACC_W-1:0] q_early,
  output logic signed [ACC_W-1:0] i_prompt,
  output logic signed [ACC_W-1:0] q_prompt,
  output logic signed [ACC_W-1:0] i_late,
  output logic signed [ACC_W-1:0] q_late,
  output logic                    acc_valid,
  output logic                    overrun,
  output logic [7:0]              dump_count
);

  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t acc_add(input acc_t a, input acc_t b);
`ifdef CORR_SATURATE_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree only on overflow; the extra bit carries the true sign.
    unique case (s[ACC_W:ACC_W-1])
      2'b01:   return {1'b0, {(ACC_W-1){1'b1}}};
      2'b10:   return {1'b1, {(ACC_W-1){1'b0}}};
      default: return s[ACC_W-1:0];
    endcase
`else
    return a + b;
`endif
  endfunction

  // Slot order: 0 IE, 1 QE, 2 IP, 3 QP, 4 IL, 5 QL.
  acc_t       acc_q [6];
  acc_t       acc_d [6];
  acc_t       lat_q [6];
  acc_t       lat_d [6];
  acc_t       sum   [6];
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic [7:0] cnt_q, cnt_d;

  acc_t       ext_i, ext_q;
  logic [5:0] chip;

  assign ext_i = {{(ACC_W-IN_W){mix_i[IN_W-1]}}, mix_i};
  assign ext_q = {{(ACC_W-IN_W){mix_q[IN_W-1]}}, mix_q};
  assign chip  = {late, late, prompt, prompt, early, early};

  // Running value including this cycle's sample; feeds both the integrator and the dump latch.
  always_comb begin
    acc_t x;
    acc_t term;
    for (int k = 0; k < 6; k++) begin
      x    = (k % 2 == 0) ? ext_i : ext_q;
      term = chip[k] ? -x : x;
      sum[k] = sample_enable ? acc_add(acc_q[k], term) : acc_q[k];
    end
  end

  always_comb begin
    acc_d   = acc_q;
    lat_d   = lat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (prn_key_enable) begin
      acc_d   = '{default: '0};
      lat_d   = '{default: '0};
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      cnt_d   = '0;
    end else if (dump_enable) begin
      lat_d   = sum;
      acc_d   = '{default: '0};
      valid_d = 1'b1;
      // A coincident acknowledge consumed the old set, so nothing was lost.
      ovr_d   = valid_q & ~acc_ack;
      cnt_d   = cnt_q + 8'd1;
    end else begin
      if (sample_enable) acc_d = sum;
      if (acc_ack) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q   <= '{default: '0};
      lat_q   <= '{default: '0};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      lat_q   <= lat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign i_early    = lat_q[0];
  assign q_early    = lat_q[1];
  assign i_prompt   = lat_q[2];
  assign q_prompt   = lat_q[3];
  assign i_late     = lat_q[4];
  assign q_late     = lat_q[5];
  assign acc_valid  = valid_q;
  assign overrun    = ovr_q;
  assign dump_count = cnt_q;

endmodule

// File: tb/tb_code_correlator.sv
// Self-checking bench for code_correlator: directed scenarios plus random traffic against an
// integer reference model. Honours CORR_SATURATE_EN the same way as the design.
module tb_code_correlator;

  localparam int IN_W  = 4;
  localparam int ACC_W = 16;
  localparam longint AccMax = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AccMin = -(AccMax + 1);
  localparam longint AccMod = longint'(1) << ACC_W;

  logic clk = 1'b0;
  logic rstn;
  logic prn_key_enable, sample_enable, early, prompt, late, dump_enable, acc_ack;
  logic signed [IN_W-1:0]  mix_i, mix_q;
  logic signed [ACC_W-1:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
  logic       acc_valid, overrun;
  logic [7:0] dump_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_correlator #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .prn_key_enable(prn_key_enable),
    .sample_enable (sample_enable),
    .mix_i         (mix_i),
    .mix_q         (mix_q),
    .early         (early),
    .prompt        (prompt),
    .late          (late),
    .dump_enable   (dump_enable),
    .acc_ack       (acc_ack),
    .i_early       (i_early),
    .q_early       (q_early),
    .i_prompt      (i_prompt),
    .q_prompt      (q_prompt),
    .i_late        (i_late),
    .q_late        (q_late),
    .acc_valid     (acc_valid),
    .overrun       (overrun),
    .dump_count    (dump_count)
  );

  // Reference model: plain integer sums of +/-1 times the sample.
  longint m_run[6];
  longint m_lat[6];
  int     m_valid, m_ovr, m_cnt;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic longint fix(input longint v);
`ifdef CORR_SATURATE_EN
    if (v > AccMax) return AccMax;
    if (v < AccMin) return AccMin;
    return v;
`else
    longint m;
    m = v % AccMod;
    if (m < 0) m += AccMod;
    if (m > AccMax) m -= AccMod;
    return m;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      m_run[k] = 0;
      m_lat[k] = 0;
    end
    m_valid = 0;
    m_ovr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    longint x, s, contrib;
    logic   c;
    if (prn_key_enable) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 6; k++) begin
      x = (k % 2 == 0) ? longint'(mix_i) : longint'(mix_q);
      c = (k < 2) ? early : (k < 4) ? prompt : late;
      contrib = sample_enable ? (c ? -x : x) : 0;
      s = fix(m_run[k] + contrib);
      if (dump_enable) begin
        m_lat[k] = s;
        m_run[k] = 0;
      end else if (sample_enable) begin
        m_run[k] = s;
      end
    end
    if (dump_enable) begin
      m_ovr   = (m_valid != 0 && !acc_ack) ? 1 : 0;
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 256;
    end else if (acc_ack) begin
      m_valid = 0;
      m_ovr   = 0;
    end
  endtask

  task automatic check_all();
    check_eq("i_early",    i_early,    m_lat[0]);
    check_eq("q_early",    q_early,    m_lat[1]);
    check_eq("i_prompt",   i_prompt,   m_lat[2]);
    check_eq("q_prompt",   q_prompt,   m_lat[3]);
    check_eq("i_late",     i_late,     m_lat[4]);
    check_eq("q_late",     q_late,     m_lat[5]);
    check_eq("acc_valid",  {63'd0, acc_valid}, m_valid);
    check_eq("overrun",    {63'd0, overrun},   m_ovr);
    check_eq("dump_count", {56'd0, dump_count}, m_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    prn_key_enable = 1'b0;
    sample_enable  = 1'b0;
    early          = 1'b0;
    prompt         = 1'b0;
    late           = 1'b0;
    dump_enable    = 1'b0;
    acc_ack        = 1'b0;
    mix_i          = '0;
    mix_q          = '0;
  endtask

  int gap;

  initial begin
    idle();
    rstn = 1'b0;
    model_reset();
    #12;
    check_all();
    rstn = 1'b1;

    // Basic accumulate: 10 samples, dump on the 10th.
    mix_i = 4'sd3;
    mix_q = -4'sd2;
    sample_enable = 1'b1;
    repeat (9) tick();
    dump_enable = 1'b1;
    tick();
    dump_enable = 1'b0;
    check_eq("basic_i_early", i_early, 30);
    check_eq("basic_q_late", q_late, -20);
    check_eq("basic_valid", {63'd0, acc_valid}, 1);
    check_eq("basic_count", {56'd0, dump_count}, 1);

    // Chip sign and spacing.
    sample_enable = 1'b0;
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    early = 1'b1; prompt = 1'b0; late = 1'b1;
    mix_i = 4'sd5; mix_q = 4'sd0;
    sample_enable = 1'b1;
    repeat (3) tick();
    dump_enable = 1'b1;
    tick();
    dump_enable = 1'b0;
    check_eq("chip_i_early", i_early, -20);
    check_eq("chip_i_prompt", i_prompt, 20);
    check_eq("chip_i_late", i_late, -20);

    // Overrun: restart, then two dumps without acknowledge.
    idle();
    prn_key_enable = 1'b1;
    tick();
    prn_key_enable = 1'b0;
    sample_enable = 1'b1;
    mix_i = 4'sd1;
    repeat (4) tick();
    dump_enable = 1'b1;
    tick();
    dump_enable = 1'b0;
    mix_i = 4'sd2;
    repeat (2) tick();
    dump_enable = 1'b1;
    tick();
    dump_enable = 1'b0;
    sample_enable = 1'b0;
    check_eq("ovr_flag", {63'd0, overrun}, 1);
    check_eq("ovr_i_prompt", i_prompt, 6);
    check_eq("ovr_count", {56'd0, dump_count}, 2);
    acc_ack = 1'b1;
    tick();
    acc_ack = 1'b0;
    check_eq("ack_valid", {63'd0, acc_valid}, 0);
    check_eq("ack_overrun", {63'd0, overrun}, 0);

    // Dump and acknowledge together, first with overrun clear, then with it set.
    dump_enable = 1'b1;
    tick();
    acc_ack = 1'b1;
    tick();
    check_eq("dumpack_valid", {63'd0, acc_valid}, 1);
    check_eq("dumpack_overrun", {63'd0, overrun}, 0);
    acc_ack = 1'b0;
    tick();
    check_eq("dump_sets_ovr", {63'd0, overrun}, 1);
    acc_ack = 1'b1;
    tick();
    check_eq("dumpack_clr_ovr", {63'd0, overrun}, 0);
    acc_ack = 1'b0;
    dump_enable = 1'b0;

    // Restart beats a coincident dump.
    sample_enable = 1'b1;
    mix_i = 4'sd4;
    repeat (3) tick();
    prn_key_enable = 1'b1;
    dump_enable = 1'b1;
    acc_ack = 1'b1;
    tick();
    idle();
    check_eq("prn_i_prompt", i_prompt, 0);
    check_eq("prn_valid", {63'd0, acc_valid}, 0);
    check_eq("prn_count", {56'd0, dump_count}, 0);

    // Saturation / wrap: 5000 samples of +7.
    mix_i = 4'sd7;
    sample_enable = 1'b1;
    repeat (4999) tick();
    dump_enable = 1'b1;
    tick();
    idle();
`ifdef CORR_SATURATE_EN
    check_eq("sat_i_prompt", i_prompt, 32767);
`else
    check_eq("wrap_i_prompt", i_prompt, -30536);
`endif

    // Random traffic, including occasional back-to-back dumps and restarts.
    gap = 5;
    for (int n = 0; n < 3000; n++) begin
      sample_enable  = ($urandom_range(0, 3) != 0);
      mix_i          = IN_W'($urandom);
      mix_q          = IN_W'($urandom);
      early          = 1'($urandom);
      prompt         = 1'($urandom);
      late           = 1'($urandom);
      acc_ack        = ($urandom_range(0, 7) == 0);
      prn_key_enable = ($urandom_range(0, 299) == 0);
      if (gap == 0) begin
        dump_enable = 1'b1;
        gap = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      end else begin
        dump_enable = 1'b0;
        gap--;
      end
      tick();
    end
    idle();

    // Asynchronous reset between edges.
    sample_enable = 1'b1;
    repeat (100) begin
      mix_i = IN_W'($urandom);
      mix_q = IN_W'($urandom);
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("arst_count", {56'd0, dump_count}, 0);
    #2;
    rstn = 1'b1;
    idle();
    mix_i = 4'sd1;
    sample_enable = 1'b1;
    repeat (2) tick();
    dump_enable = 1'b1;
    tick();
    idle();
    check_eq("arst_i_prompt", i_prompt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
